// File: rtl/alu_operand_stage_pkg.sv
// Shared types and helpers for the ALU operand-B stage: source-select
// encoding and the lane slicing arithmetic used on packed lane buses.
package pipe_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        SRC_REG    = 2'd0,
        SRC_IMM    = 2'd1,
        SRC_FWD_EX = 2'd2,
        SRC_FWD_WB = 2'd3
    } src_sel_t;

    // Bit offset of lane 'lane' inside a packed bus of 'width'-bit lanes.
    function automatic int lane_base(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand bundle between the register file / immediate decoder and the
// ID/EX operand register. The master drives operands and control; the
// slave (the operand stage) returns the registered operand.
interface alu_operand_stage_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int IMM_W = 16
);
    logic                     stall;
    logic                     flush;
    logic                     in_valid;
    logic [1:0]               src_sel;
    logic                     imm_sext;
    logic                     imm_bcast;
    logic [LANES-1:0]         lane_mask;
    logic [LANES*WIDTH-1:0]   reg_b;
    logic [IMM_W-1:0]         imm;
    logic [LANES*WIDTH-1:0]   fwd_ex;
    logic [LANES*WIDTH-1:0]   fwd_wb;
    logic [LANES*WIDTH-1:0]   op_out;
    logic                     out_valid;
    logic [1:0]               sel_q;

    modport master (
        output stall, flush, in_valid, src_sel, imm_sext, imm_bcast,
               lane_mask, reg_b, imm, fwd_ex, fwd_wb,
        input  op_out, out_valid, sel_q
    );

    modport slave (
        input  stall, flush, in_valid, src_sel, imm_sext, imm_bcast,
               lane_mask, reg_b, imm, fwd_ex, fwd_wb,
        output op_out, out_valid, sel_q
    );
endinterface

// File: rtl/alu_operand_stage_lane_sel.sv
// Combinational per-lane operand multiplexer. A masked-off lane, an
// immediate on a lane that does not receive it, and any unresolved select
// value all give zero so nothing undefined reaches the ALU.
module operand_lane_sel
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  src_sel_t         i_sel,
    input  logic             i_mask,
    input  logic [WIDTH-1:0] i_reg,
    input  logic [WIDTH-1:0] i_imm_ext,
    input  logic [WIDTH-1:0] i_fwd_ex,
    input  logic [WIDTH-1:0] i_fwd_wb,
    input  logic             i_imm_en,
    output logic [WIDTH-1:0] o_lane
);

    // Select this lane's operand source, zero when disabled.
    always_comb begin
        o_lane = {WIDTH{1'b0}};
        if (i_mask) begin
            case (i_sel)
                SRC_REG:    o_lane = i_reg;
                SRC_IMM: begin
                    if (i_imm_en) begin
                        o_lane = i_imm_ext;
                    end else begin
                        o_lane = {WIDTH{1'b0}};
                    end
                end
                SRC_FWD_EX: o_lane = i_fwd_ex;
                SRC_FWD_WB: o_lane = i_fwd_wb;
                default:    o_lane = {WIDTH{1'b0}};
            endcase
        end else begin
            o_lane = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand-B stage for the SIMD pipeline: extends the immediate, selects
// each lane's operand and registers the result at the ID/EX boundary with
// flush/stall control. Outputs come only from registers (1-cycle latency).
module alu_operand_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int IMM_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus
);

    logic                   w_fill;
    logic [WIDTH+IMM_W-1:0] w_imm_wide;
    logic [WIDTH-1:0]       w_imm_ext;
    logic                   w_imm_unused;
    logic [LANES-1:0]       w_imm_en;
    logic [LANES*WIDTH-1:0] w_next_op;
    src_sel_t               w_sel;

    logic [LANES*WIDTH-1:0] r_op_out;
    logic                   r_out_valid;
    logic [1:0]             r_sel_q;

    // Place the fill bits above the raw immediate and keep the low WIDTH
    // bits: this covers narrower (extend), equal (pass) and wider
    // (truncate, sign choice irrelevant) immediates with one expression.
    assign w_fill       = bus.imm_sext & bus.imm[IMM_W-1];
    assign w_imm_wide   = {{WIDTH{w_fill}}, bus.imm};
    assign w_imm_ext    = w_imm_wide[WIDTH-1:0];
    assign w_imm_unused = ^w_imm_wide[WIDTH+IMM_W-1:WIDTH];

    assign w_sel = src_sel_t'(bus.src_sel);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Lane 0 always receives the immediate; others only on broadcast.
        if (i == 0) begin : g_imm_en0
            assign w_imm_en[i] = 1'b1;
        end else begin : g_imm_enn
            assign w_imm_en[i] = bus.imm_bcast;
        end

        operand_lane_sel #(
            .WIDTH (WIDTH)
        ) u_lane_sel (
            .i_sel     (w_sel),
            .i_mask    (bus.lane_mask[i]),
            .i_reg     (bus.reg_b [lane_base(i, WIDTH) +: WIDTH]),
            .i_imm_ext (w_imm_ext),
            .i_fwd_ex  (bus.fwd_ex[lane_base(i, WIDTH) +: WIDTH]),
            .i_fwd_wb  (bus.fwd_wb[lane_base(i, WIDTH) +: WIDTH]),
            .i_imm_en  (w_imm_en[i]),
            .o_lane    (w_next_op[lane_base(i, WIDTH) +: WIDTH])
        );
    end

    // ID/EX operand register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_out    <= {(LANES*WIDTH){1'b0}};
            r_out_valid <= 1'b0;
            r_sel_q     <= 2'd0;
        end else if (bus.flush) begin
            r_op_out    <= {(LANES*WIDTH){1'b0}};
            r_out_valid <= 1'b0;
            r_sel_q     <= 2'd0;
        end else if (bus.stall) begin
            r_op_out    <= r_op_out;
            r_out_valid <= r_out_valid;
            r_sel_q     <= r_sel_q;
        end else begin
            r_op_out    <= w_next_op;
            r_out_valid <= bus.in_valid;
            r_sel_q     <= bus.src_sel;
        end
    end

    assign bus.op_out    = r_op_out;
    assign bus.out_valid = r_out_valid;
    assign bus.sel_q     = r_sel_q;

endmodule
